// File: rtl/theta_recover_pkg.sv
// Shared constants, state encoding and angle table for the theta recovery CORDIC.
// Angles are Q3.29 radians; the z accumulator carries two extra integer bits of headroom.
package theta_recover_pkg;

    localparam int IN_W = 32;
    localparam int TH_W = 32;
    localparam int Z_W  = 34;

    localparam logic signed [TH_W-1:0] PI_Q329      = 32'sh6487ED51;
    localparam logic signed [TH_W-1:0] HALF_PI_Q329 = 32'sh3243F6A9;
    localparam logic signed [Z_W-1:0]  PI_Z         = 34'sd1686629713;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_ITER,
        ST_POST,
        ST_DONE
    } state_t;

    // atan(2^-i) in Q3.29, rounded to nearest; from i=10 on it rounds to exactly 2^(29-i)
    function automatic logic signed [Z_W-1:0] atan_lut(input logic [4:0] idx);
        case (idx)
            5'd0:    atan_lut = 34'sd421657428;
            5'd1:    atan_lut = 34'sd248918915;
            5'd2:    atan_lut = 34'sd131521918;
            5'd3:    atan_lut = 34'sd66762579;
            5'd4:    atan_lut = 34'sd33510843;
            5'd5:    atan_lut = 34'sd16771758;
            5'd6:    atan_lut = 34'sd8387925;
            5'd7:    atan_lut = 34'sd4194219;
            5'd8:    atan_lut = 34'sd2097141;
            5'd9:    atan_lut = 34'sd1048575;
            5'd30,
            5'd31:   atan_lut = '0;
            default: atan_lut = 34'sd1 <<< (5'd29 - idx);
        endcase
    endfunction

    // Clamp to [-pi, +pi] and fold -pi onto +pi so the result lies in (-pi, +pi]
    function automatic logic [TH_W-1:0] sat_theta(input logic signed [Z_W-1:0] z);
        if ((z >= PI_Z) || (z <= -PI_Z)) begin
            sat_theta = PI_Q329;
        end else begin
            sat_theta = z[TH_W-1:0];
        end
    endfunction

endpackage

// File: rtl/theta_cordic_stage.sv
// One combinational CORDIC vectoring iteration; the shift index also selects the table angle.
module theta_cordic_stage
    import theta_recover_pkg::*;
#(
    parameter int IW = 36
)
(
    input  logic signed [IW-1:0]  x_cur,
    input  logic signed [IW-1:0]  y_cur,
    input  logic signed [Z_W-1:0] z_cur,
    input  logic [4:0]            shift,
    output logic signed [IW-1:0]  x_nxt,
    output logic signed [IW-1:0]  y_nxt,
    output logic signed [Z_W-1:0] z_nxt
);

    logic signed [IW-1:0]  x_sh;
    logic signed [IW-1:0]  y_sh;
    logic signed [Z_W-1:0] ang;

    always_comb begin
        x_sh = x_cur >>> shift;
        y_sh = y_cur >>> shift;
        ang  = atan_lut(shift);
        if (!y_cur[IW-1]) begin
            x_nxt = x_cur + y_sh;
            y_nxt = y_cur - x_sh;
            z_nxt = z_cur + ang;
        end else begin
            x_nxt = x_cur - y_sh;
            y_nxt = y_cur + x_sh;
            z_nxt = z_cur - ang;
        end
    end

endmodule

// File: rtl/theta_recover_system.sv
// Recovers the angle atan2(sin, cos) with an iterative CORDIC in vectoring mode.
// Fixed latency: done_sig fires ITER+3 cycles after the accepted start strobe.
module theta_recover_system
    import theta_recover_pkg::*;
#(
    parameter int ITER = 28,
    parameter int IW   = 36
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        sta,
    input  logic [31:0] cos_in,
    input  logic [31:0] sin_in,
    output logic [31:0] theta,
    output logic        done_sig,
    output logic        busy
);

    localparam logic [4:0] LAST_CNT = 5'(ITER - 1);

    state_t                state;
    state_t                state_nxt;
    logic signed [IW-1:0]  x;
    logic signed [IW-1:0]  y;
    logic signed [Z_W-1:0] z;
    logic signed [IW-1:0]  x_nxt;
    logic signed [IW-1:0]  y_nxt;
    logic signed [Z_W-1:0] z_nxt;
    logic [4:0]            cnt;
    logic                  zero_in;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (sta) state_nxt = ST_PRE;
            ST_PRE:  state_nxt = ST_ITER;
            ST_ITER: if (cnt == LAST_CNT) state_nxt = ST_POST;
            ST_POST: state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    theta_cordic_stage #(.IW(IW)) u_stage (
        .x_cur (x),
        .y_cur (y),
        .z_cur (z),
        .shift (cnt),
        .x_nxt (x_nxt),
        .y_nxt (y_nxt),
        .z_nxt (z_nxt)
    );

    // Left half-plane vectors are rotated by pi first so the iterations only cover +/- pi/2
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x       <= '0;
            y       <= '0;
            z       <= '0;
            cnt     <= '0;
            zero_in <= 1'b0;
            theta   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (sta) begin
                        x <= {{(IW-IN_W){cos_in[31]}}, cos_in};
                        y <= {{(IW-IN_W){sin_in[31]}}, sin_in};
                    end
                end
                ST_PRE: begin
                    cnt     <= '0;
                    zero_in <= (x == '0) && (y == '0);
                    if (x[IW-1]) begin
                        x <= -x;
                        y <= -y;
                        z <= y[IW-1] ? -PI_Z : PI_Z;
                    end else begin
                        z <= '0;
                    end
                end
                ST_ITER: begin
                    x   <= x_nxt;
                    y   <= y_nxt;
                    z   <= z_nxt;
                    cnt <= cnt + 5'd1;
                end
                ST_POST: begin
                    theta <= zero_in ? '0 : sat_theta(z);
                end
                default: ;
            endcase
        end
    end

    assign busy     = (state != ST_IDLE);
    assign done_sig = (state == ST_DONE);

endmodule

// File: tb/tb_theta_recover_system.sv
// Scoreboard bench for theta_recover_system: expected angles are queued at each accepted
// start strobe and checked against theta, with latency, when done_sig appears.
module tb_theta_recover_system;

    localparam int  ITER  = 28;
    localparam int  LAT   = ITER + 3;
    localparam longint PI_L = 64'sd1686629713;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sta = 1'b0;
    logic [31:0] cos_in = '0;
    logic [31:0] sin_in = '0;
    logic [31:0] theta;
    logic        done_sig;
    logic        busy;

    theta_recover_system #(.ITER(ITER), .IW(36)) dut (
        .clk      (clk),
        .rst      (rst),
        .sta      (sta),
        .cos_in   (cos_in),
        .sin_in   (sin_in),
        .theta    (theta),
        .done_sig (done_sig),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       tag;
        logic [31:0] exp;
        int          tol;
        bit          nonneg;
        longint      sta_cyc;
    } sb_t;

    sb_t sb[$];
    int  tests    = 0;
    int  fails    = 0;
    int  done_cnt = 0;
    int  pushes   = 0;

    // Angle comparisons with a tolerance use the wrapped difference so +pi and -pi meet
    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp, input int tol);
        longint d;
        bit     bad;
        tests++;
        if (tol == 0) begin
            bad = (obs !== exp);
        end else begin
            d = longint'($signed(obs)) - longint'($signed(exp));
            if (d > PI_L)  d = d - 2 * PI_L;
            if (d < -PI_L) d = d + 2 * PI_L;
            if (d < 0)     d = -d;
            bad = (^obs === 1'bx) || (d > tol);
        end
        if (bad) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    function automatic logic [31:0] modelTheta(input logic [31:0] c, input logic [31:0] s);
        real    rc;
        real    rs;
        longint q;
        if ((c == 0) && (s == 0)) return 32'h0;
        rc = $itor($signed(c)) / 1073741824.0;
        rs = $itor($signed(s)) / 1073741824.0;
        q  = longint'($atan2(rs, rc) * 536870912.0);
        return q[31:0];
    endfunction

    function automatic real magSq(input logic [31:0] c, input logic [31:0] s);
        real rc;
        real rs;
        rc = $itor($signed(c)) / 1073741824.0;
        rs = $itor($signed(s)) / 1073741824.0;
        return rc * rc + rs * rs;
    endfunction

    always @(negedge clk) begin
        if (rst && done_sig) begin
            sb_t e;
            done_cnt++;
            if (sb.size() == 0) begin
                checkOutput("unexpected_done", 32'd1, 32'd0, 0);
            end else begin
                e = sb.pop_front();
                checkOutput($sformatf("%s_theta", e.tag), theta, e.exp, e.tol);
                checkOutput($sformatf("%s_lat", e.tag), 32'(cyc - e.sta_cyc), 32'(LAT), 0);
                if (e.nonneg) checkOutput($sformatf("%s_sign", e.tag), {31'd0, theta[31]}, 32'd0, 0);
            end
        end
    end

    // Called at a falling edge; returns at the next falling edge with sta dropped
    task automatic driveSta(input logic [31:0] c, input logic [31:0] s);
        sta    = 1'b1;
        cos_in = c;
        sin_in = s;
        @(negedge clk);
        sta    = 1'b0;
        cos_in = $urandom;
        sin_in = $urandom;
    endtask

    task automatic applyStimulus(input string tag, input logic [31:0] c, input logic [31:0] s,
                                 input logic [31:0] exp, input int tol, input bit nonneg);
        sb_t e;
        e.tag     = tag;
        e.exp     = exp;
        e.tol     = tol;
        e.nonneg  = nonneg;
        e.sta_cyc = cyc;
        sb.push_back(e);
        pushes++;
        driveSta(c, s);
        checkOutput($sformatf("%s_busy", tag), {31'd0, busy}, 32'd1, 0);
    endtask

    task automatic waitIdle(input int max_cycles);
        int n = 0;
        while (((sb.size() != 0) || busy) && (n < max_cycles)) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain", 32'(sb.size()), 32'd0, 0);
    endtask

    initial begin
        logic [31:0] c;
        logic [31:0] s;
        int          n;

        repeat (3) @(negedge clk);
        checkOutput("rst_theta", theta, 32'h0, 0);
        checkOutput("rst_done", {31'd0, done_sig}, 32'd0, 0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0, 0);
        rst = 1'b1;
        @(negedge clk);

        applyStimulus("zero_deg", 32'h40000000, 32'h00000000, 32'h00000000, 16, 1'b0);
        waitIdle(100);
        applyStimulus("ninety", 32'h00000000, 32'h40000000, 32'h3243F6A9, 16, 1'b0);
        waitIdle(100);
        applyStimulus("pi", 32'hC0000000, 32'h00000000, 32'h6487ED51, 16, 1'b1);
        waitIdle(100);
        applyStimulus("m3pi4", 32'hE0000000, 32'hE0000000, 32'hB49A0E03, 16, 1'b0);
        waitIdle(100);

        for (int k = 0; k < 6; k++) begin
            c = $urandom;
            s = $urandom;
            for (int t = 0; (t < 20) && (magSq(c, s) < 0.25); t++) begin
                c = $urandom;
                s = $urandom;
            end
            if (magSq(c, s) < 0.25) begin
                c = 32'h30000000;
                s = 32'hD0000000;
            end
            applyStimulus($sformatf("rnd%0d", k), c, s, modelTheta(c, s), 16, 1'b0);
            waitIdle(100);
        end

        // Second strobe ten cycles into a computation must be ignored
        applyStimulus("origin", 32'h00000000, 32'h00000000, 32'h00000000, 0, 1'b0);
        repeat (9) @(negedge clk);
        driveSta(32'h40000000, 32'h40000000);
        waitIdle(100);
        repeat (40) @(negedge clk);
        checkOutput("origin_hold", theta, 32'h00000000, 0);

        // Strobe in the DONE cycle is dropped, the next IDLE cycle is accepted
        applyStimulus("b2b_a", 32'h2D413CCD, 32'h2D413CCD, 32'h1921FB54, 16, 1'b0);
        n = 0;
        while (!done_sig && (n < 60)) begin
            @(negedge clk);
            n++;
        end
        checkOutput("b2b_seen", {31'd0, done_sig}, 32'd1, 0);
        driveSta(32'h40000000, 32'h00000000);
        applyStimulus("b2b_b", 32'h00000000, 32'hC0000000, 32'hCDBC0957, 16, 1'b0);
        waitIdle(100);

        // Abort mid-computation with reset
        driveSta(32'h40000000, 32'h40000000);
        repeat (14) @(negedge clk);
        checkOutput("hold_theta", theta, 32'hCDBC0957, 16);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("abort_theta", theta, 32'h0, 0);
        checkOutput("abort_done", {31'd0, done_sig}, 32'd0, 0);
        checkOutput("abort_busy", {31'd0, busy}, 32'd0, 0);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        checkOutput("abort_idle", {31'd0, busy}, 32'd0, 0);

        applyStimulus("post_rst", 32'h40000000, 32'h40000000, 32'h1921FB54, 16, 1'b0);
        waitIdle(100);
        repeat (5) @(negedge clk);
        checkOutput("done_count", 32'(done_cnt), 32'(pushes), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
